// File: rtl/ads1256_acq_sequencer.sv
// Acquisition sequencer for the ADS1256: WREG config, SELFCAL, then RDATA or RDATAC sampling.
// Issues commands to the SPI transaction layer and assembles 24-bit samples from its read strobes.
//
// state      | meaning
// IDLE       | waiting for enable_i
// CFG_ISSUE  | start WREG for config register idx
// CFG_WAIT   | waiting for WREG done
// CAL_ISSUE  | start SELFCAL
// CAL_WAIT   | waiting for SELFCAL done
// RUN_ISSUE  | start RDATA, or stop on enable drop / target reached
// RUN_WAIT   | waiting for RDATA done
// CONT_ISSUE | start RDATAC
// CONT_RUN   | streaming; SDATAC queued on enable drop / target reached
// STOP_WAIT  | waiting for SDATAC done
// ERROR      | timeout seen; held until reset
module ads1256_acq_sequencer #(
    parameter int NUM_CFG        = 4,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                 clock_i,
    input  logic                 reset_L_i,
    input  logic                 enable_i,
    input  logic                 mode_cont_i,
    input  logic [CNT_W-1:0]     num_samples_i,
    input  logic [8*NUM_CFG-1:0] cfg_regs_i,
    output logic                 txn_start_o,
    output logic [23:0]          txn_cmd_o,
    input  logic                 txn_done_i,
    input  logic                 read_reg_load_i,
    input  logic [1:0]           read_reg_sel_i,
    input  logic [7:0]           rx_byte_i,
    output logic [23:0]          sample_o,
    output logic                 sample_valid_o,
    output logic [CNT_W-1:0]     sample_count_o,
    output logic                 busy_o,
    output logic                 config_done_o,
    output logic                 error_o
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_CFG_ISSUE  = 4'd1;
    localparam logic [3:0] S_CFG_WAIT   = 4'd2;
    localparam logic [3:0] S_CAL_ISSUE  = 4'd3;
    localparam logic [3:0] S_CAL_WAIT   = 4'd4;
    localparam logic [3:0] S_RUN_ISSUE  = 4'd5;
    localparam logic [3:0] S_RUN_WAIT   = 4'd6;
    localparam logic [3:0] S_CONT_ISSUE = 4'd7;
    localparam logic [3:0] S_CONT_RUN   = 4'd8;
    localparam logic [3:0] S_STOP_WAIT  = 4'd9;
    localparam logic [3:0] S_ERROR      = 4'd10;

    localparam logic [23:0] CMD_SELFCAL = 24'hF0FFFF;
    localparam logic [23:0] CMD_RDATA   = 24'h01FFFF;
    localparam logic [23:0] CMD_RDATAC  = 24'h03FFFF;
    localparam logic [23:0] CMD_SDATAC  = 24'h0FFFFF;

    localparam int             TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]     IDX_LAST = 4'(NUM_CFG - 1);

    logic [3:0]           state;
    logic [3:0]           state_nxt;
    logic [23:0]          cmd_nxt;
    logic [TMR_W-1:0]     timer;
    logic [3:0]           idx;
    logic [3:0]           idx_inc;
    logic                 mode_r;
    logic [CNT_W-1:0]     num_r;
    logic [8*NUM_CFG-1:0] cfg_r;
    logic [127:0]         cfg_wide;
    logic [7:0]           b2;
    logic [7:0]           b1;
    logic                 target_hit;
    logic                 in_wait;
    logic                 in_issue;
    logic                 timed_out;

    function automatic logic [23:0] wreg_cmd(input logic [3:0] addr, input logic [7:0] data);
        return {4'h5, addr, 8'h00, data};
    endfunction

    assign idx_inc    = idx + 4'd1;
    assign cfg_wide   = 128'(cfg_r);
    assign target_hit = (num_r != '0) && (sample_count_o >= num_r);
    assign in_wait    = state inside {S_CFG_WAIT, S_CAL_WAIT, S_RUN_WAIT, S_STOP_WAIT};
    assign in_issue   = state inside {S_CFG_ISSUE, S_CAL_ISSUE, S_RUN_ISSUE, S_CONT_ISSUE};
    assign timed_out  = in_wait && (timer == TMR_LAST);
    assign busy_o     = (state != S_IDLE);

    // RUN_ISSUE only starts RDATA when it is not about to fall back to IDLE
    always_comb begin
        txn_start_o = 1'b0;
        case (state)
            S_CFG_ISSUE, S_CAL_ISSUE, S_CONT_ISSUE: txn_start_o = 1'b1;
            S_RUN_ISSUE: txn_start_o = enable_i && !target_hit;
            default:     txn_start_o = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cmd_nxt   = txn_cmd_o;
        case (state)
            S_IDLE: if (enable_i) begin
                state_nxt = S_CFG_ISSUE;
                cmd_nxt   = wreg_cmd(4'd0, cfg_regs_i[7:0]);
            end
            S_CFG_ISSUE: state_nxt = S_CFG_WAIT;
            S_CFG_WAIT: if (txn_done_i) begin
                if (idx == IDX_LAST) begin
                    state_nxt = S_CAL_ISSUE;
                    cmd_nxt   = CMD_SELFCAL;
                end else begin
                    state_nxt = S_CFG_ISSUE;
                    cmd_nxt   = wreg_cmd(idx_inc, cfg_wide[{idx_inc, 3'b000} +: 8]);
                end
            end else if (timed_out) begin
                state_nxt = S_ERROR;
            end
            S_CAL_ISSUE: state_nxt = S_CAL_WAIT;
            S_CAL_WAIT: if (txn_done_i) begin
                state_nxt = mode_r ? S_CONT_ISSUE : S_RUN_ISSUE;
                cmd_nxt   = mode_r ? CMD_RDATAC : CMD_RDATA;
            end else if (timed_out) begin
                state_nxt = S_ERROR;
            end
            S_RUN_ISSUE: state_nxt = (!enable_i || target_hit) ? S_IDLE : S_RUN_WAIT;
            S_RUN_WAIT: if (txn_done_i) begin
                state_nxt = S_RUN_ISSUE;
                cmd_nxt   = CMD_RDATA;
            end else if (timed_out) begin
                state_nxt = S_ERROR;
            end
            S_CONT_ISSUE: state_nxt = S_CONT_RUN;
            // SDATAC is loaded without a start; the layer picks it up at its next DRDY
            S_CONT_RUN: if (!enable_i || target_hit) begin
                state_nxt = S_STOP_WAIT;
                cmd_nxt   = CMD_SDATAC;
            end
            S_STOP_WAIT: if (txn_done_i) begin
                state_nxt = S_IDLE;
            end else if (timed_out) begin
                state_nxt = S_ERROR;
            end
            S_ERROR: state_nxt = S_ERROR;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_L_i) begin
        if (!reset_L_i) begin
            state          <= S_IDLE;
            txn_cmd_o      <= 24'h0;
            timer          <= '0;
            idx            <= 4'd0;
            mode_r         <= 1'b0;
            num_r          <= '0;
            cfg_r          <= '0;
            b2             <= 8'h0;
            b1             <= 8'h0;
            sample_o       <= 24'h0;
            sample_valid_o <= 1'b0;
            sample_count_o <= '0;
            config_done_o  <= 1'b0;
            error_o        <= 1'b0;
        end else begin
            state          <= state_nxt;
            txn_cmd_o      <= cmd_nxt;
            sample_valid_o <= 1'b0;

            if (in_issue) begin
                timer <= '0;
            end else if (in_wait) begin
                timer <= timer + TMR_W'(1);
            end

            if (state == S_CFG_WAIT && txn_done_i && idx != IDX_LAST) begin
                idx <= idx_inc;
            end

            if (state_nxt == S_IDLE) begin
                config_done_o <= 1'b0;
            end else if (state == S_CAL_WAIT && txn_done_i) begin
                config_done_o <= 1'b1;
            end

            if (state_nxt == S_ERROR) begin
                error_o <= 1'b1;
            end

            if (state == S_IDLE) begin
                if (enable_i) begin
                    mode_r         <= mode_cont_i;
                    num_r          <= num_samples_i;
                    cfg_r          <= cfg_regs_i;
                    idx            <= 4'd0;
                    sample_count_o <= '0;
                end
            end else if (read_reg_load_i) begin
                case (read_reg_sel_i)
                    2'd1: b2 <= rx_byte_i;
                    2'd2: b1 <= rx_byte_i;
                    2'd3: begin
                        sample_o       <= {b2, b1, rx_byte_i};
                        sample_valid_o <= 1'b1;
                        if (sample_count_o != '1) begin
                            sample_count_o <= sample_count_o + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ads1256_acq_sequencer.sv
// Scoreboard bench for ads1256_acq_sequencer: expected commands and samples are queued by the
// stimulus and popped by a monitor whenever the DUT starts a transaction or reports a sample.
module tb_ads1256_acq_sequencer;

    logic        clock_i = 1'b0;
    logic        reset_L_i = 1'b0;
    logic        enable_i = 1'b0;
    logic        mode_cont_i = 1'b0;
    logic [15:0] num_samples_i = '0;
    logic [31:0] cfg_regs_i = '0;
    logic        txn_start_o;
    logic [23:0] txn_cmd_o;
    logic        txn_done_i = 1'b0;
    logic        read_reg_load_i = 1'b0;
    logic [1:0]  read_reg_sel_i = 2'd0;
    logic [7:0]  rx_byte_i = 8'h0;
    logic [23:0] sample_o;
    logic        sample_valid_o;
    logic [15:0] sample_count_o;
    logic        busy_o;
    logic        config_done_o;
    logic        error_o;

    int total  = 0;
    int passed = 0;
    int exp_cnt = 0;
    logic [23:0] exp_cmd_q[$];
    logic [39:0] exp_smp_q[$];

    always #5 clock_i = ~clock_i;

    ads1256_acq_sequencer #(.NUM_CFG(4), .CNT_W(16), .TIMEOUT_CYCLES(16)) dut (
        .clock_i(clock_i), .reset_L_i(reset_L_i), .enable_i(enable_i),
        .mode_cont_i(mode_cont_i), .num_samples_i(num_samples_i), .cfg_regs_i(cfg_regs_i),
        .txn_start_o(txn_start_o), .txn_cmd_o(txn_cmd_o), .txn_done_i(txn_done_i),
        .read_reg_load_i(read_reg_load_i), .read_reg_sel_i(read_reg_sel_i), .rx_byte_i(rx_byte_i),
        .sample_o(sample_o), .sample_valid_o(sample_valid_o), .sample_count_o(sample_count_o),
        .busy_o(busy_o), .config_done_o(config_done_o), .error_o(error_o)
    );

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // monitor: every start and every sample pulse must match the head of its queue
    initial forever begin
        @(negedge clock_i);
        if (txn_start_o === 1'b1) begin
            if (exp_cmd_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_start: cmd %h, expected no start", txn_cmd_o);
            end else check("start_cmd", {16'h0, txn_cmd_o}, {16'h0, exp_cmd_q.pop_front()});
        end
        if (sample_valid_o === 1'b1) begin
            if (exp_smp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_sample: got %h count %0d, expected no sample", sample_o, sample_count_o);
            end else check("sample_and_count", {sample_count_o, sample_o}, exp_smp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock_i);
        #1;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        do begin
            @(negedge clock_i);
            n++;
        end while (txn_start_o !== 1'b1 && n < 100);
        if (txn_start_o !== 1'b1) begin
            total++;
            $display("FAIL %s: got no start in 100 cycles, expected start", name);
        end
    endtask

    task automatic do_done;
        tick;
        tick;
        txn_done_i = 1'b1;
        tick;
        txn_done_i = 1'b0;
    endtask

    task automatic run_cfg(input logic [31:0] cfg, input logic mode, input logic [15:0] num);
        cfg_regs_i    = cfg;
        mode_cont_i   = mode;
        num_samples_i = num;
        exp_cnt       = 0;
        for (int k = 0; k < 4; k++) exp_cmd_q.push_back({4'h5, 4'(k), 8'h00, cfg[8*k +: 8]});
        exp_cmd_q.push_back(24'hF0FFFF);
        if (mode) exp_cmd_q.push_back(24'h03FFFF);
        enable_i = 1'b1;
        @(negedge clock_i);
        check("no_start_in_idle", {39'h0, txn_start_o}, 40'h0);
        for (int i = 0; i < 5; i++) begin
            wait_start("cfg_start");
            if (i == 0) cfg_regs_i = '0;
            if (i == 4) check("config_done_before_cal", {39'h0, config_done_o}, 40'h0);
            do_done;
        end
        check("config_done_after_cal", {39'h0, config_done_o}, 40'h1);
    endtask

    task automatic strobes(input logic [7:0] x2, input logic [7:0] x1, input logic [7:0] x0, input logic junk);
        exp_cnt++;
        exp_smp_q.push_back({16'(exp_cnt), x2, x1, x0});
        read_reg_load_i = 1'b1;
        read_reg_sel_i  = 2'd1; rx_byte_i = x2; tick;
        if (junk) begin
            read_reg_sel_i = 2'd0; rx_byte_i = 8'h55; tick;
        end
        read_reg_sel_i  = 2'd2; rx_byte_i = x1; tick;
        read_reg_sel_i  = 2'd3; rx_byte_i = x0; tick;
        read_reg_load_i = 1'b0; read_reg_sel_i = 2'd0; rx_byte_i = 8'h0;
    endtask

    task automatic rdata_txn(input logic [7:0] x2, input logic [7:0] x1, input logic [7:0] x0,
                             input logic junk, input logic drop_en);
        exp_cmd_q.push_back(24'h01FFFF);
        wait_start("rdata_start");
        tick;
        strobes(x2, x1, x0, junk);
        txn_done_i = 1'b1;
        if (drop_en) enable_i = 1'b0;
        tick;
        txn_done_i = 1'b0;
    endtask

    initial begin
        // reset state
        #3;
        check("rst_busy", {39'h0, busy_o}, 40'h0);
        check("rst_start_cmd", {15'h0, txn_start_o, txn_cmd_o}, 40'h0);
        check("rst_sample", {sample_count_o, sample_o}, 40'h0);
        check("rst_flags", {37'h0, sample_valid_o, config_done_o, error_o}, 40'h0);
        #9 reset_L_i = 1'b1;
        tick;
        tick;

        // config sequence then RDATA with a target of 3
        run_cfg(32'hF0200131, 1'b0, 16'd3);
        rdata_txn(8'hAB, 8'hCD, 8'hEF, 1'b0, 1'b0);
        rdata_txn(8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
        rdata_txn(8'h80, 8'h00, 8'h01, 1'b0, 1'b0);
        check("no_start_at_target", {39'h0, txn_start_o}, 40'h0);
        check("busy_in_run_issue", {39'h0, busy_o}, 40'h1);
        tick;
        enable_i = 1'b0;
        check("idle_after_target", {39'h0, busy_o}, 40'h0);
        check("count_after_target", {24'h0, sample_count_o}, 40'd3);
        check("config_done_cleared", {39'h0, config_done_o}, 40'h0);
        tick;

        // sel 0 ignored; done and enable drop together in RUN_WAIT
        run_cfg(32'h01020304, 1'b0, 16'd0);
        rdata_txn(8'h12, 8'h34, 8'h56, 1'b1, 1'b0);
        rdata_txn(8'h9A, 8'hBC, 8'hDE, 1'b0, 1'b1);
        check("no_start_after_drop", {39'h0, txn_start_o}, 40'h0);
        check("one_more_run_issue", {39'h0, busy_o}, 40'h1);
        tick;
        check("idle_after_drop", {39'h0, busy_o}, 40'h0);
        check("count_after_drop", {24'h0, sample_count_o}, 40'd2);
        tick;

        // RDATAC streaming, stopped by enable drop after 5 samples
        run_cfg(32'hA5A5A5A5, 1'b1, 16'd0);
        wait_start("rdatac_start");
        tick;
        for (int i = 0; i < 5; i++) begin
            logic [7:0] v;
            v = 8'(i);
            strobes(8'hF0 | v, 8'h20 + v, 8'h0F ^ v, 1'b0);
            tick;
        end
        enable_i = 1'b0;
        tick;
        check("sdatac_loaded", {16'h0, txn_cmd_o}, 40'h0FFFFF);
        check("busy_in_stop_wait", {39'h0, busy_o}, 40'h1);
        tick;
        txn_done_i = 1'b1;
        tick;
        txn_done_i = 1'b0;
        check("idle_after_sdatac", {39'h0, busy_o}, 40'h0);
        check("count_after_cont", {24'h0, sample_count_o}, 40'd5);
        tick;

        // async reset in the middle of CONT_RUN
        run_cfg(32'h11223344, 1'b1, 16'd0);
        wait_start("rdatac_start2");
        tick;
        strobes(8'hC0, 8'hFF, 8'hEE, 1'b0);
        read_reg_load_i = 1'b1; read_reg_sel_i = 2'd1; rx_byte_i = 8'h77;
        tick;
        read_reg_load_i = 1'b0; read_reg_sel_i = 2'd0;
        #2 reset_L_i = 1'b0;
        #1;
        check("async_rst_busy", {39'h0, busy_o}, 40'h0);
        check("async_rst_cmd", {15'h0, txn_start_o, txn_cmd_o}, 40'h0);
        check("async_rst_sample", {sample_count_o, sample_o}, 40'h0);
        check("async_rst_flags", {37'h0, sample_valid_o, config_done_o, error_o}, 40'h0);
        enable_i = 1'b0;
        #2 reset_L_i = 1'b1;
        tick;
        tick;
        check("idle_after_release", {39'h0, busy_o}, 40'h0);

        // timeout: done never arrives
        cfg_regs_i = 32'h00000011;
        exp_cmd_q.push_back(24'h500011);
        enable_i = 1'b1;
        wait_start("timeout_start");
        repeat (16) @(negedge clock_i);
        check("error_before_timeout", {39'h0, error_o}, 40'h0);
        @(negedge clock_i);
        check("error_at_timeout", {39'h0, error_o}, 40'h1);
        repeat (20) @(negedge clock_i);
        check("error_sticky", {38'h0, error_o, busy_o}, 40'h3);
        check("no_start_in_error", {39'h0, txn_start_o}, 40'h0);

        check("cmd_queue_drained", 40'(exp_cmd_q.size()), 40'h0);
        check("sample_queue_drained", 40'(exp_smp_q.size()), 40'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
